// File: rtl/async_output_driver_if.sv
// Pin-side bundle of async_output_driver: level/pulse requests in, pin drive and strobes out.
interface async_output_driver_if;
  logic i_level;
  logic i_pulse_req;
  logic o_pin;
  logic o_busy;
  logic o_rising_edge;
  logic o_falling_edge;

  modport master (output i_level, i_pulse_req,
                  input  o_pin, o_busy, o_rising_edge, o_falling_edge);
  modport slave  (input  i_level, i_pulse_req,
                  output o_pin, o_busy, o_rising_edge, o_falling_edge);
endinterface

// File: rtl/async_output_driver.sv
// Output pin driver enforcing a minimum level hold, with optional single-shot pulses
// (pulse machinery compiled in when ASYNC_OUTPUT_DRIVER_PULSE_EN is defined).
module async_output_driver #(
  parameter int MIN_HOLD_CLKS = 5,
  parameter int PULSE_CLKS    = 8,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic                  clock,
  input  logic                  i_reset,
  async_output_driver_if.slave  bus
);

`ifdef ASYNC_OUTPUT_DRIVER_PULSE_EN
  localparam int CW = $clog2(PULSE_CLKS + 1);
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_PULSE_WAIT, S_PULSE, S_RECOVER} state_e;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CLKS - 1);
`else
  localparam int CW = $clog2(MIN_HOLD_CLKS);
  typedef enum logic {S_IDLE, S_HOLD} state_e;
`endif
  localparam logic [CW-1:0] HOLD_MAX = CW'(MIN_HOLD_CLKS - 1);

  state_e          state_q, state_d;
  logic            pin_q, pin_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rise_q, fall_q;
  logic            restart;
  logic            expired, hold_done;

  // HOLD looks one edge ahead so IDLE can act on the very edge the hold ends
  assign expired   = (cnt_q >= HOLD_MAX);
  assign hold_done = (cnt_q >= HOLD_MAX - CW'(1));

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_HOLD;
      pin_q   <= RESET_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      rise_q  <= pin_d & ~pin_q;
      fall_q  <= ~pin_d & pin_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pin_d   = pin_q;
    restart = 1'b0;
    unique case (state_q)
`ifdef ASYNC_OUTPUT_DRIVER_PULSE_EN
      S_IDLE: begin
        if (bus.i_pulse_req) begin
          pin_d   = ~pin_q;
          state_d = S_PULSE;
        end else if (bus.i_level != pin_q) begin
          pin_d   = bus.i_level;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.i_pulse_req)  state_d = S_PULSE_WAIT;
        else if (hold_done)   state_d = S_IDLE;
      end
      S_PULSE_WAIT: begin
        if (expired) begin
          pin_d   = ~pin_q;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        // recovery hold restarts even when the pin does not move at pulse end
        if (cnt_q == PULSE_LAST) begin
          pin_d   = bus.i_level;
          restart = 1'b1;
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (expired) state_d = S_IDLE;
      end
`else
      S_IDLE: begin
        if (bus.i_level != pin_q) begin
          pin_d   = bus.i_level;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_done) state_d = S_IDLE;
      end
`endif
      default: state_d = S_HOLD;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((pin_d != pin_q) || restart)
      cnt_d = '0;
`ifdef ASYNC_OUTPUT_DRIVER_PULSE_EN
    else if (state_q == S_PULSE)
      cnt_d = cnt_q + CW'(1);
`endif
    else if (!expired)
      cnt_d = cnt_q + CW'(1);
  end

  logic busy;
  always_comb begin
    busy = 1'b0;
`ifdef ASYNC_OUTPUT_DRIVER_PULSE_EN
    busy = (state_q == S_PULSE_WAIT) || (state_q == S_PULSE) || (state_q == S_RECOVER);
`endif
  end

  assign bus.o_pin          = pin_q;
  assign bus.o_busy         = busy;
  assign bus.o_rising_edge  = rise_q;
  assign bus.o_falling_edge = fall_q;

endmodule

// File: tb/tb_async_output_driver.sv
// Randomized and directed check of async_output_driver against a timestamp-based model.
module tb_async_output_driver;
  localparam int MH = 5;
  localparam int PW = 8;
  localparam bit RL = 1'b0;

  logic clock = 1'b0;
  logic i_reset;
  async_output_driver_if bus();

  async_output_driver #(.MIN_HOLD_CLKS(MH), .PULSE_CLKS(PW), .RESET_LEVEL(RL)) dut (
    .clock(clock), .i_reset(i_reset), .bus(bus.slave));

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;

  // model: edge index n since reset, time of last pin change, mode of pulse sequence
  localparam int M_FREE = 0, M_WAIT = 1, M_PULSE = 2, M_REC = 3;
  int n, t_chg, t_rec, mode;
  bit m_pin, m_rise, m_fall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    n = 0; t_chg = 0; t_rec = 0; mode = M_FREE;
    m_pin = RL; m_rise = 1'b0; m_fall = 1'b0;
  endfunction

  function automatic void model_edge(input bit lvl, input bit req_in);
    bit old, req;
    old = m_pin;
    req = req_in;
`ifndef ASYNC_OUTPUT_DRIVER_PULSE_EN
    req = 1'b0;
`endif
    n++;
    case (mode)
      M_PULSE: if (n - t_chg == PW) begin
        m_pin = lvl;
        if (m_pin != old) t_chg = n;
        t_rec = n; mode = M_REC;
      end
      M_REC:  if (n - t_rec >= MH) mode = M_FREE;
      M_WAIT: if (n - t_chg >= MH) begin
        m_pin = ~m_pin; t_chg = n; mode = M_PULSE;
      end
      default: begin
        if (n - t_chg >= MH) begin
          if (req) begin m_pin = ~m_pin; t_chg = n; mode = M_PULSE; end
          else if (lvl != m_pin) begin m_pin = lvl; t_chg = n; end
        end else if (req) mode = M_WAIT;
      end
    endcase
    m_rise = !old && m_pin;
    m_fall = old && !m_pin;
  endfunction

  task automatic step(input bit lvl, input bit req);
    bus.i_level = lvl;
    bus.i_pulse_req = req;
    @(posedge clock);
    model_edge(lvl, req);
    #1;
    chk($sformatf("pin@%0d", n),  bus.o_pin, m_pin);
    chk($sformatf("busy@%0d", n), bus.o_busy, mode != M_FREE);
    chk($sformatf("rise@%0d", n), bus.o_rising_edge, m_rise);
    chk($sformatf("fall@%0d", n), bus.o_falling_edge, m_fall);
    chk($sformatf("both@%0d", n), bus.o_rising_edge & bus.o_falling_edge, 1'b0);
    bus.i_pulse_req = 1'b0;
  endtask

  task automatic settle(input bit lvl);
    for (int i = 0; i < 16; i++) step(lvl, 1'b0);
  endtask

  task automatic do_reset(input bit lvl);
    bus.i_level = lvl;
    bus.i_pulse_req = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    chk("rst_pin",  bus.o_pin, RL);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_rise", bus.o_rising_edge, 1'b0);
    chk("rst_fall", bus.o_falling_edge, 1'b0);
    @(posedge clock);
    #1 i_reset = 1'b0;
    model_reset();
  endtask

  int cnt_a, cnt_b, cnt_c, idx_a, idx_b;
  bit prev, lvl_r;

  initial begin
    i_reset = 1'b1;
    bus.i_level = 1'b1;
    bus.i_pulse_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("init_pin",  bus.o_pin, RL);
    chk("init_busy", bus.o_busy, 1'b0);
    i_reset = 1'b0;

    // level 1 held through reset: rise exactly on the 5th edge after release
    cnt_a = 0; idx_a = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (bus.o_rising_edge) begin cnt_a++; if (idx_a < 0) idx_a = i; end
    end
    chk("reset_rise_idx", idx_a, 5);
    chk("reset_rise_cnt", cnt_a, 1);

    // one-clock glitch to 1 from 0: pin high for exactly 5 clocks
    settle(1'b0);
    cnt_a = 0; cnt_b = 0; idx_a = -1;
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 1'b0);
      if (bus.o_pin) cnt_a++;
      if (bus.o_falling_edge) begin cnt_b++; idx_a = i; end
    end
    chk("glitch_high", cnt_a, 5);
    chk("glitch_fall_cnt", cnt_b, 1);
    chk("glitch_fall_idx", idx_a, 5);

    // pulse from idle low, second request 3 clocks later
    settle(1'b0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, (i == 0) || (i == 3));
      if (bus.o_pin) cnt_a++;
      if (bus.o_busy) cnt_b++;
    end
`ifdef ASYNC_OUTPUT_DRIVER_PULSE_EN
    chk("pulse_width", cnt_a, 8);
    chk("pulse_busy",  cnt_b, 13);
`else
    chk("nopulse_pin",  cnt_a, 0);
    chk("nopulse_busy", cnt_b, 0);
`endif

    // request 2 clocks after a level change waits out the hold
    settle(1'b0);
    idx_a = -1; idx_b = -1; cnt_b = 0; prev = 1'b0;
    for (int i = 0; i < 21; i++) begin
      step(1'b1, i == 2);
      if (prev && !bus.o_pin && idx_a < 0) idx_a = i;
      if (!prev && bus.o_pin && idx_a >= 0 && idx_b < 0) idx_b = i;
      if (bus.o_busy) cnt_b++;
      prev = bus.o_pin;
    end
`ifdef ASYNC_OUTPUT_DRIVER_PULSE_EN
    chk("wait_start", idx_a, 5);
    chk("wait_end",   idx_b, 13);
    chk("wait_busy",  cnt_b, 16);
`else
    chk("nowait_start", idx_a, -1);
    chk("nowait_busy",  cnt_b, 0);
`endif

    // level rises to the pulsed level mid-pulse: no edge at pulse end
    settle(1'b0);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 21; i++) begin
      step(i >= 3, i == 0);
      if (bus.o_pin) cnt_a++;
      if (bus.o_busy) cnt_b++;
      if (bus.o_falling_edge) cnt_c++;
    end
`ifdef ASYNC_OUTPUT_DRIVER_PULSE_EN
    chk("merge_high", cnt_a, 21);
    chk("merge_busy", cnt_b, 13);
`else
    chk("merge_high", cnt_a, 18);
    chk("merge_busy", cnt_b, 0);
`endif
    chk("merge_fall", cnt_c, 0);

    // reset on the 4th clock of a pulse
    settle(1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    do_reset(1'b1);
    cnt_a = 0; idx_a = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (bus.o_rising_edge) begin cnt_a++; if (idx_a < 0) idx_a = i; end
    end
    chk("midrst_rise_idx", idx_a, 5);
    chk("midrst_rise_cnt", cnt_a, 1);

    // random traffic against the model
    lvl_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset(lvl_r);
      if ($urandom_range(0, 5) == 0) lvl_r = ~lvl_r;
      step(lvl_r, $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/async_output_driver.md
# async_output_driver

Transmit-side counterpart to the board input filters. Drives a CPLD output pin from a synchronous level request and guarantees that every level on the pin lasts at least MIN_HOLD_CLKS clocks, so a glitch-filtering receiver at the far end never discards it. It also generates fixed-width single-shot pulses on request and reports pin edges with one-clock strobes. It sits between core control logic and output pins such as platform reset and power-good.

## Interface
- MIN_HOLD_CLKS, 5: minimum clocks any pin level is held. Must be ≥2.
- PULSE_CLKS, 8: width of a requested pulse in clocks. Must be ≥ MIN_HOLD_CLKS.
- RESET_LEVEL, 0: o_pin value during and after reset.
- clock  input  1  master clock; the only clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_level  input  1  requested steady pin level; synchronous to clock.
- i_pulse_req  input  1  one-clock request for a pulse of PULSE_CLKS to the inverse of the current pin level.
- o_pin  output  1  registered pin drive.
- o_busy  output  1  pulse sequence in progress; i_pulse_req is ignored while high.
- o_rising_edge  output  1  high for one clock, in the same cycle o_pin first shows 1 after 0.
- o_falling_edge  output  1  high for one clock, in the same cycle o_pin first shows 0 after 1.

## Operation
- Hold counter: cleared on every o_pin change and saturates at MIN_HOLD_CLKS−1. "Hold expired" means the counter is saturated. Counter width is $clog2(PULSE_CLKS+1).
- Reset values:
  - o_pin = RESET_LEVEL; o_busy, o_rising_edge and o_falling_edge = 0.
  - Hold counter = 0, so the reset level is held MIN_HOLD_CLKS clocks after reset release.
  - State = HOLD.
- State machine:
  - IDLE: hold expired. If i_pulse_req, go to PULSE, drive ~o_pin and assert o_busy. Otherwise, if i_level ≠ o_pin, drive i_level and go to HOLD. Pulse takes priority when both occur in the same cycle.
  - HOLD: i_level changes are not applied. On hold expired, go to IDLE. A pending i_pulse_req is latched and moves the state to PULSE_WAIT.
  - PULSE_WAIT: o_busy = 1. When hold expires, drive ~o_pin and go to PULSE.
  - PULSE: pin is held inverted for exactly PULSE_CLKS clocks. Then drive the current i_level and go to RECOVER. If the current i_level equals the pulsed level, no edge occurs and the pin stays.
  - RECOVER: o_busy = 1 until hold expires, then go to IDLE with o_busy = 0.
- i_level changes during PULSE_WAIT, PULSE or RECOVER are not queued. Only the i_level value sampled at each decision point matters.
- Reset asserted mid-operation: the async return to the reset values is immediate. The pulse in progress is dropped and no edge strobe is generated by reset.

## Timing
- Unconstrained level change: i_level sampled at edge k updates o_pin at edge k, with the strobe in the same cycle. Latency is 1 clock.
- Consecutive o_pin changes are separated by at least MIN_HOLD_CLKS edges. Pulses are exactly PULSE_CLKS wide.
- Pulse request accepted at edge k in IDLE:
  - o_pin inverts at edge k and o_busy = 1 from edge k.
  - o_pin returns at edge k+PULSE_CLKS.
  - o_busy drops at edge k+PULSE_CLKS+MIN_HOLD_CLKS.
- o_rising_edge and o_falling_edge are never high together, and never high for two consecutive clocks.

## Configuration
- ASYNC_OUTPUT_DRIVER_PULSE_EN defined: the pulse machinery (PULSE_WAIT, PULSE, RECOVER, o_busy) is compiled in as described above.
- Not defined:
  - i_pulse_req is ignored and o_busy is tied to 0.
  - Only the IDLE and HOLD states exist, and PULSE_CLKS is unused.
  - Level behaviour and edge strobes are unchanged.

## Test plan
Defaults are MIN_HOLD_CLKS=5, PULSE_CLKS=8, RESET_LEVEL=0.
- Reset with i_level=1 held through release → o_pin stays 0 for 5 clocks after release, then rises with o_rising_edge high for exactly 1 clock.
- Glitch: i_level=1 for 1 clock, then 0 → o_pin high for exactly 5 clocks, then falls with o_falling_edge.
- Pulse request in IDLE with o_pin=0 → o_pin high for exactly 8 clocks; o_busy high for 13 clocks; a second i_pulse_req 3 clocks later is ignored.
- Pulse request arriving 2 clocks after a level change → PULSE_WAIT for 3 clocks, then an 8-clock pulse; the minimum 5-clock spacing is preserved.
- i_level toggles to 1 during a pulse from low → at the pulse end o_pin stays 1 with no strobe; o_busy clears 5 clocks later.
- i_reset asserted at the 4th clock of a pulse → o_pin=0 and o_busy=0 immediately; no strobe; the 5-clock hold applies after release.
- Compiled without ASYNC_OUTPUT_DRIVER_PULSE_EN → i_pulse_req has no effect and o_busy is constantly 0.
